// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer for the 16-bit WISC core: owns the PC, drives a
// variable-latency instruction port, loads IF/ID and absorbs decode stalls in a skid.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        halted_q, halted_d;

  logic        ifv_q, ifv_d;
  logic [15:0] ifi_q, ifi_d;
  logic [15:0] ifp_q, ifp_d;
  logic [15:0] ifp2_q, ifp2_d;

  logic        skv_q, skv_d;
  logic [15:0] ski_q, ski_d;
  logic [15:0] skp_q, skp_d;

  logic resp;
  logic pending;
  logic resp_halt;

  // Only a FETCH-state completion is a usable instruction; DRAIN completions are wrong-path.
  assign resp      = (state_q == S_FETCH) && req_q && imem_rdy;
  assign pending   = req_q && !imem_rdy;
  assign resp_halt = (imem_data[15:12] == HALT_OP);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the branches below can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    ifv_d    = ifv_q;
    ifi_d    = ifi_q;
    ifp_d    = ifp_q;
    ifp2_d   = ifp2_q;
    skv_d    = skv_q;
    ski_d    = ski_q;
    skp_d    = skp_q;

    if (state_q == S_IDLE) begin
      state_d = S_FETCH;
    end else if (br_taken) begin
      // A flush beats stalls and any same-cycle response, including a HALT.
      ifv_d    = 1'b0;
      skv_d    = 1'b0;
      pc_d     = br_target;
      halted_d = 1'b0;
      state_d  = pending ? S_DRAIN : S_FETCH;
    end else begin
      if (!id_stall) begin
        if (skv_q) begin
          ifv_d  = 1'b1;
          ifi_d  = ski_q;
          ifp_d  = skp_q;
          ifp2_d = skp_q + 16'd2;
          skv_d  = 1'b0;
        end else if (resp) begin
          ifv_d  = 1'b1;
          ifi_d  = imem_data;
          ifp_d  = addr_q;
          ifp2_d = addr_q + 16'd2;
        end else begin
          ifv_d = 1'b0;
        end
      end else if (resp) begin
        // Request is held low while the skid is full, so this never overwrites it.
        skv_d = 1'b1;
        ski_d = imem_data;
        skp_d = addr_q;
      end

      case (state_q)
        S_FETCH: begin
          if (resp) begin
            if (resp_halt) begin
              state_d  = S_HALTED;
              halted_d = 1'b1;
              pc_d     = addr_q;
            end else begin
              pc_d = addr_q + 16'd2;
            end
          end
        end
        S_DRAIN: begin
          if (imem_rdy) state_d = S_FETCH;
        end
        default: ;
      endcase
    end

    req_d  = ((state_d == S_FETCH) && !skv_d) || (state_d == S_DRAIN);
    // The address follows pc until a request is in flight, then freezes until it completes.
    addr_d = pending ? addr_q : pc_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      ifv_q    <= 1'b0;
      ifi_q    <= 16'h0000;
      ifp_q    <= 16'h0000;
      ifp2_q   <= 16'h0000;
      skv_q    <= 1'b0;
      ski_q    <= 16'h0000;
      skp_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      ifv_q    <= ifv_d;
      ifi_q    <= ifi_d;
      ifp_q    <= ifp_d;
      ifp2_q   <= ifp2_d;
      skv_q    <= skv_d;
      ski_q    <= ski_d;
      skp_q    <= skp_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = ifv_q;
  assign if_instr    = ifi_q;
  assign if_pc       = ifp_q;
  assign if_pc_plus2 = ifp2_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
